ex_wb_pipe: RTL and testbench
=============================

Name: ex_wb_pipe

Overview:
- Parametrised successor to the fixed-width EX/WB pipeline register.
- Carries the ALU result, writeback address/enable, writeback-mux select, PC+4 and load control from EX to WB.
- Adds a valid/ready handshake so WB can stall EX.
- Adds a flush input and x0 write suppression.
- Adds an optional skid buffer so in_ready_o is driven straight from a flop.

Parameters:
XLEN, 32, width of alu_result and pc_plus datapaths
REG_AW, 5, register-file address width
WRMUX_W, 2, width of writeback-mux select
LOAD_W, 3, width of load-control field

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
flush_i  input  1  discard all held entries at next edge
in_valid_i  input  1  EX presents a valid instruction
in_ready_o  output  1  stage can accept this cycle
alu_result_i  input  XLEN  ALU result
wb_addr_i  input  REG_AW  destination register
wb_en_i  input  1  instruction writes the register file
control_wr_mux_i  input  WRMUX_W  writeback source select
pc_plus_i  input  XLEN  PC+4 for JAL/JALR
control_load_i  input  LOAD_W  load size/sign control
out_valid_o  output  1  WB-side entry valid
out_ready_i  input  1  WB consumes entry this cycle
alu_result_o  output  XLEN  held ALU result
wb_addr_o  output  REG_AW  held destination
wb_en_o  output  1  write enable; only 1 when out_valid_o=1
control_wr_mux_o  output  WRMUX_W  held select
pc_plus_o  output  XLEN  held PC+4
control_load_o  output  LOAD_W  held load control

Behaviour:
- Transfers:
  - Input transfer (accept): in_valid_i & in_ready_o.
  - Output transfer (pop): out_valid_o & out_ready_i.
- Reset (rst=0 at a rising edge): all valid flags are 0 and every data/control output is 0. in_ready_o=1 in the cycle after reset.
- Storage is a main register (drives the outputs) plus, when the skid feature is built, a skid register. Every field is captured together.
- Capture rule: the stored wb_en is wb_en_i & (wb_addr_i != 0), so x0 is never written.
- wb_en_o = main_valid & stored wb_en.
- Data outputs hold their last value when invalid; they are not zeroed except by reset.
- Latency: 1 cycle from accept to out_valid_o when the stage was empty.
- Throughput: 1 instruction/cycle while out_ready_i=1.
- State machine, with the skid feature built:
  - EMPTY: main=0, skid=0. Accept → FULL.
  - FULL: main=1, skid=0.
    - Accept and pop → FULL, main reloads from the input.
    - Accept, no pop → SKID, input goes to the skid register.
    - Pop, no accept → EMPTY.
  - SKID: main=1, skid=1. in_ready_o=0.
    - Pop → FULL, skid moves to main.
    - Otherwise hold.
  - Without the skid feature only EMPTY and FULL exist (see Optional Feature).
- in_ready_o must never assert while both registers are valid. Input is not captured in a cycle with in_ready_o=0.
- Flush:
  - flush_i=1 at an edge forces EMPTY.
  - An input presented in the same cycle is discarded, even if in_ready_o=1.
  - The upstream stage sees the accept and treats it as killed.
  - A pop in the flush cycle still counts as a completed pop for WB.
- Reset has priority over flush. Reset during SKID or FULL drops all entries, with no partial writeback.
- in_valid_i is sampled only at the edge; glitches between edges have no effect.

Optional Feature:
- Macro: EX_WB_SKID_EN.
- Defined:
  - Two-entry storage as above.
  - in_ready_o = !skid_valid, taken directly from a register with no combinational path from out_ready_i.
- Undefined:
  - Single register.
  - in_ready_o = !main_valid | out_ready_i (combinational pass-through).
  - An accept while full without a pop is impossible.
  - All other rules (x0 suppression, flush, reset) are identical.

Test Plan:
- Reset, then stream: rst=0 for 2 cycles, then stream 3 instructions (alu=0x10/0x20/0x30, addr=1/2/3, wb_en=1) with out_ready_i=1 → out_valid_o high on cycles 1-3 after each accept, outputs in order, wb_en_o=1.
- x0 suppression: accept wb_addr_i=0, wb_en_i=1, alu=0xDEADBEEF → out_valid_o=1, alu_result_o=0xDEADBEEF, wb_en_o=0.
- Backpressure, skid build: out_ready_i=0 and accept A (alu=0xA), then B (alu=0xB) → in_ready_o=0 after B. Raise out_ready_i → A popped, then B, no loss or duplication. in_ready_o returns to 1 one cycle after the first pop.
- Flush: in SKID state assert flush_i with in_valid_i=1 (alu=0xC) → next cycle out_valid_o=0, in_ready_o=1, 0xC never appears.
- Mid-operation reset: rst=0 while FULL with alu=0x55, wb_en=1 → next cycle out_valid_o=0, wb_en_o=0, all outputs 0.
- Non-skid build: out_ready_i toggling 1,0,1 with continuous in_valid_i → in_ready_o follows !main_valid|out_ready_i each cycle, 2 pops in 3 cycles.

Source files
------------

// File: rtl/ex_wb_pipe.sv
// EX/WB pipeline register with valid/ready handshake, flush and x0 write suppression.
// Define EX_WB_SKID_EN to add a skid register so in_ready_o comes straight from a flop.
module ex_wb_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned WRMUX_W = 2,
  parameter int unsigned LOAD_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic [REG_AW-1:0]  wb_addr_i,
  input  logic               wb_en_i,
  input  logic [WRMUX_W-1:0] control_wr_mux_i,
  input  logic [XLEN-1:0]    pc_plus_i,
  input  logic [LOAD_W-1:0]  control_load_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    alu_result_o,
  output logic [REG_AW-1:0]  wb_addr_o,
  output logic               wb_en_o,
  output logic [WRMUX_W-1:0] control_wr_mux_o,
  output logic [XLEN-1:0]    pc_plus_o,
  output logic [LOAD_W-1:0]  control_load_o
);

  localparam int unsigned PW = 2 * XLEN + REG_AW + 1 + WRMUX_W + LOAD_W;

  // Bit 0 is main-valid, bit 1 is skid-valid, so both can be read directly from the flops.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b01,
    StSkid  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   in_pack;
  logic            in_wb_en;
  logic            main_wb_en;
  logic            main_valid;
  logic            accept;
  logic            pop;

  assign in_wb_en = wb_en_i & (wb_addr_i != '0);
  assign in_pack  = {alu_result_i, wb_addr_i, in_wb_en, control_wr_mux_i, pc_plus_i,
                     control_load_i};

  assign main_valid  = state_q[0];
  assign out_valid_o = main_valid;

`ifdef EX_WB_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  assign in_ready_o = ~state_q[1];
`else
  assign in_ready_o = ~main_valid | out_ready_i;
`endif

  assign accept = in_valid_i & in_ready_o;
  assign pop    = main_valid & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef EX_WB_SKID_EN
    skid_d  = skid_q;
`endif
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          main_d  = in_pack;
        end
      end
      StFull: begin
        if (accept) begin
`ifdef EX_WB_SKID_EN
          if (pop) begin
            main_d = in_pack;
          end else begin
            state_d = StSkid;
            skid_d  = in_pack;
          end
`else
          // Accept while full implies a pop in this build.
          main_d = in_pack;
`endif
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
`ifdef EX_WB_SKID_EN
        if (pop) begin
          state_d = StFull;
          main_d  = skid_q;
        end
`else
        state_d = StEmpty;
`endif
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops every entry and the incoming one; held data stays visible but invalid.
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = main_q;
`ifdef EX_WB_SKID_EN
      skid_d  = skid_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
`ifdef EX_WB_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef EX_WB_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  assign {alu_result_o, wb_addr_o, main_wb_en, control_wr_mux_o, pc_plus_o,
          control_load_o} = main_q;
  assign wb_en_o = main_valid & main_wb_en;

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Randomized self-checking bench for ex_wb_pipe against a queue-based reference model.
// Honours EX_WB_SKID_EN to pick the expected buffering depth and ready rule.
module tb_ex_wb_pipe;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  addr;
    logic        wben;
    logic [1:0]  mux;
    logic [31:0] pc;
    logic [2:0]  load;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] alu_result_i;
  logic [4:0]  wb_addr_i;
  logic        wb_en_i;
  logic [1:0]  control_wr_mux_i;
  logic [31:0] pc_plus_i;
  logic [2:0]  control_load_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] alu_result_o;
  logic [4:0]  wb_addr_o;
  logic        wb_en_o;
  logic [1:0]  control_wr_mux_o;
  logic [31:0] pc_plus_o;
  logic [2:0]  control_load_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  item_t q[$];
  item_t last;
  bit    armed = 1'b0;

  always #5 clk = ~clk;

  ex_wb_pipe #(
    .XLEN    (32),
    .REG_AW  (5),
    .WRMUX_W (2),
    .LOAD_W  (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .alu_result_i     (alu_result_i),
    .wb_addr_i        (wb_addr_i),
    .wb_en_i          (wb_en_i),
    .control_wr_mux_i (control_wr_mux_i),
    .pc_plus_i        (pc_plus_i),
    .control_load_i   (control_load_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .alu_result_o     (alu_result_o),
    .wb_addr_o        (wb_addr_o),
    .wb_en_o          (wb_en_o),
    .control_wr_mux_o (control_wr_mux_o),
    .pc_plus_o        (pc_plus_o),
    .control_load_o   (control_load_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input bit v, input logic [31:0] alu, input logic [4:0] addr,
                     input bit wen, input logic [1:0] mux, input logic [31:0] pc,
                     input logic [2:0] load);
    in_valid_i       = v;
    alu_result_i     = alu;
    wb_addr_i        = addr;
    wb_en_i          = wen;
    control_wr_mux_i = mux;
    pc_plus_i        = pc;
    control_load_i   = load;
  endtask

  // Capacity is two with the skid register, otherwise one with pass-through ready.
  function automatic bit model_ready();
`ifdef EX_WB_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready_i;
`endif
  endfunction

  // One clock: check outputs at negedge, advance the model, return just after posedge.
  task automatic step();
    item_t exp;
    item_t nw;
    bit    rdy;
    bit    acc;
    bit    pp;
    @(negedge clk);
    rdy = model_ready();
    if (armed) begin
      exp = (q.size() > 0) ? q[0] : last;
      chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready_o), 64'(rdy));
      chk("alu_result", 64'(alu_result_o), 64'(exp.alu));
      chk("wb_addr", 64'(wb_addr_o), 64'(exp.addr));
      chk("wb_en", 64'(wb_en_o), 64'((q.size() > 0) && exp.wben));
      chk("wr_mux", 64'(control_wr_mux_o), 64'(exp.mux));
      chk("pc_plus", 64'(pc_plus_o), 64'(exp.pc));
      chk("load", 64'(control_load_o), 64'(exp.load));
    end
    if (!rst) begin
      q.delete();
      last  = '0;
      armed = 1'b1;
    end else begin
      if (q.size() > 0) last = q[0];
      acc = in_valid_i && rdy;
      pp  = (q.size() > 0) && out_ready_i;
      if (pp) void'(q.pop_front());
      if (flush_i) begin
        q.delete();
      end else if (acc) begin
        nw.alu  = alu_result_i;
        nw.addr = wb_addr_i;
        nw.wben = wb_en_i && (wb_addr_i != 5'd0);
        nw.mux  = control_wr_mux_i;
        nw.pc   = pc_plus_i;
        nw.load = control_load_i;
        q.push_back(nw);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drv(1'b0, '0, '0, 1'b0, '0, '0, '0);
    step();
    step();
    rst = 1'b1;
    step();

    // Stream three instructions at full rate.
    out_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 32'(i * 16), 5'(i), 1'b1, 2'(i), 32'(i * 4 + 4), 3'(i));
      step();
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // x0 destination must not write back.
    drv(1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 2'd1, 32'h100, 3'd2);
    step();
    in_valid_i = 1'b0;
    step();
    step();

`ifdef EX_WB_SKID_EN
    // Backpressure into the skid register, then drain.
    out_ready_i = 1'b0;
    drv(1'b1, 32'hA, 5'd4, 1'b1, 2'd0, 32'h10, 3'd0);
    step();
    drv(1'b1, 32'hB, 5'd5, 1'b1, 2'd1, 32'h14, 3'd1);
    step();
    drv(1'b1, 32'hE, 5'd6, 1'b1, 2'd2, 32'h18, 3'd2);
    step();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Flush while both entries are held, with a live input in the same cycle.
    out_ready_i = 1'b0;
    drv(1'b1, 32'hA, 5'd4, 1'b1, 2'd0, 32'h10, 3'd0);
    step();
    drv(1'b1, 32'hB, 5'd5, 1'b1, 2'd1, 32'h14, 3'd1);
    step();
    drv(1'b1, 32'hC, 5'd7, 1'b1, 2'd3, 32'h1C, 3'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    step();
`else
    // Pass-through ready with out_ready toggling under continuous input.
    out_ready_i = 1'b0;
    drv(1'b1, 32'h40, 5'd8, 1'b1, 2'd0, 32'h20, 3'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      out_ready_i = (i != 1);
      drv(1'b1, 32'(32'h41 + i), 5'(9 + i), 1'b1, 2'(i), 32'(32'h24 + 4 * i), 3'(i));
      step();
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    step();
    // Flush with a live input in the same cycle.
    out_ready_i = 1'b0;
    drv(1'b1, 32'hA, 5'd4, 1'b1, 2'd0, 32'h10, 3'd0);
    step();
    drv(1'b1, 32'hC, 5'd7, 1'b1, 2'd3, 32'h1C, 3'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
`endif

    // Reset while holding an entry clears everything.
    out_ready_i = 1'b0;
    drv(1'b1, 32'h55, 5'd3, 1'b1, 2'd2, 32'h44, 3'd5);
    step();
    in_valid_i = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 63) != 0);
      flush_i     = ($urandom_range(0, 15) == 0);
      out_ready_i = ($urandom_range(0, 9) < 6);
      drv(($urandom_range(0, 9) < 7), $urandom(), 5'($urandom_range(0, 31)),
          1'($urandom()), 2'($urandom()), $urandom(), 3'($urandom()));
      step();
    end
    rst = 1'b1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
